svc_ice40_pll_rst_seq: RTL



---
 rtl/svc_pll_pkg.sv | 20 ++
 rtl/svc_sync_bit.sv | 23 ++
 rtl/svc_ice40_pll_rst_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/svc_pll_pkg.sv
// Shared types for the iCE40 PLL reset sequencer.
package svc_pll_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_seq_state_t;

  localparam int unsigned RETRY_W = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/svc_sync_bit.sv
// Generic multi-flop single-bit synchronizer with async active-low reset.
module svc_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/svc_ice40_pll_rst_seq.sv
// PLL reset sequencer: pulses PLL RESETB, qualifies synchronized LOCK and
// releases the design reset once lock is stable; retries on timeout or loss.
module svc_ice40_pll_rst_seq
  import svc_pll_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock_i,
  output logic               pll_resetb_o,
  output logic               rst_n_o,
  output logic               locked_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  localparam int unsigned MAX_CNT = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(STABLE_CYCLES - 1);

  pll_seq_state_t   state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             retry_inc;
  logic             lock_s;

  svc_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pll_lock_i),
    .q    (lock_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - CNT_W'(1) : '0;
    retry_inc = 1'b0;
    unique case (state)
      PLL_RST: begin
        if (cnt == '0) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = TO_LOAD;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lock_s) begin
          state_nxt = STABLE;
          cnt_nxt   = STB_LOAD;
        end else if (cnt == '0) begin
          state_nxt = PLL_RST;
          cnt_nxt   = RST_LOAD;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = TO_LOAD;
        end else if (cnt == '0) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = PLL_RST;
          cnt_nxt   = RST_LOAD;
          retry_inc = 1'b1;
        end
      end
      default: begin
        state_nxt = PLL_RST;
        cnt_nxt   = RST_LOAD;
      end
    endcase
  end

  // Reset counts as PLL_RST entry, so the counter starts preloaded and the
  // first RESETB pulse is the full RST_CYCLES long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PLL_RST;
      cnt   <= RST_LOAD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_resetb_o <= 1'b0;
      rst_n_o      <= 1'b0;
      locked_o     <= 1'b0;
      retry_cnt_o  <= '0;
    end else begin
      pll_resetb_o <= (state_nxt != PLL_RST);
      rst_n_o      <= (state_nxt == RUN);
      locked_o     <= (state_nxt == RUN);
      if (retry_inc && (retry_cnt_o != '1)) begin
        retry_cnt_o <= retry_cnt_o + RETRY_W'(1);
      end
    end
  end

endmodule
